// File: rtl/rr_sel8_arbiter_pkg.sv
// Shared types and sizes for the 8-way round-robin select arbiter.
package rr_sel8_arbiter_pkg;

  localparam int unsigned NREQ       = 8;
  localparam int unsigned SEL_W      = 3;
  localparam int unsigned BURST_W    = 3;
  localparam int unsigned DATA_W_DEF = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/rr_sel8_arbiter_if.sv
// Requester/consumer bus of the arbiter: request words in, one selected word out on valid/ready.
interface rr_sel8_arbiter_if
  import rr_sel8_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
);
  logic [NREQ-1:0]        req;
  logic [NREQ*DATA_W-1:0] data_in;
  logic                   out_ready;
  logic                   out_valid;
  logic [DATA_W-1:0]      out_data;
  logic                   s0;
  logic                   s1;
  logic                   s2;
  logic [NREQ-1:0]        grant;
  logic [NREQ-1:0]        ack;

  modport master (
    output req, data_in, out_ready,
    input  out_valid, out_data, s0, s1, s2, grant, ack
  );

  modport slave (
    input  req, data_in, out_ready,
    output out_valid, out_data, s0, s1, s2, grant, ack
  );
endinterface

// File: rtl/rr_sel8_arbiter_pick8.sv
// Combinational rotating priority pick: first set request at or after start, modulo 8.
module rr_pick8
  import rr_sel8_arbiter_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] start,
  output logic             found,
  output logic [SEL_W-1:0] idx
);
  logic [SEL_W-1:0] cand;

  // Scan farthest-first so the closest set bit to start is the last to overwrite idx.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = start + SEL_W'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end
endmodule

// File: rtl/rr_sel8_arbiter.sv
// 8-way round-robin arbiter with bounded bursts; captures the winner's word and offers it on valid/ready.
module rr_sel8_arbiter
  import rr_sel8_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned HOLD_MAX = 4
)(
  input  logic                clk,
  input  logic                rst_n,
  rr_sel8_arbiter_if.slave    bus
);
  state_e             state_q, state_d;
  logic [SEL_W-1:0]   last_q, last_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [NREQ-1:0]    grant_q, grant_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               valid_q, valid_d;
  logic [DATA_W-1:0]  data_q, data_d;

  logic               pick_found;
  logic [SEL_W-1:0]   pick_idx;
  logic               hold;
  logic [SEL_W-1:0]   win;

  rr_pick8 u_pick (
    .req   (bus.req),
    .start (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // The previous winner may keep the bus only while its burst is running and below the cap.
  assign hold = bus.req[last_q] && (burst_q != '0) && (burst_q < BURST_W'(HOLD_MAX));
  assign win  = hold ? last_q : pick_idx;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    ptr_d   = ptr_q;
    burst_d = burst_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_BUSY;
          burst_d = hold ? BURST_W'(burst_q + BURST_W'(1)) : BURST_W'(1);
          last_d  = win;
          ptr_d   = SEL_W'(win + SEL_W'(1));
          grant_d = NREQ'(1) << win;
          sel_d   = win;
          data_d  = bus.data_in[int'(win) * DATA_W +: DATA_W];
          valid_d = 1'b1;
        end
      end
      ST_BUSY: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
          grant_d = '0;
          valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= '0;
      ptr_q   <= '0;
      burst_q <= '0;
      grant_q <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      ptr_q   <= ptr_d;
      burst_q <= burst_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign {bus.s2, bus.s1, bus.s0} = sel_q;
  // Ack is a same-cycle decode of the accepted transfer.
  assign bus.ack = grant_q & {NREQ{valid_q & bus.out_ready}};
endmodule

// File: tb/tb_rr_sel8_arbiter.sv
// Directed bench for rr_sel8_arbiter: two instances (HOLD_MAX=4 and HOLD_MAX=1) share one stimulus.
module tb_rr_sel8_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  req = 8'h00;
  logic [39:0] data_in = 40'h0;
  logic        out_ready = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  rr_sel8_arbiter_if #(.DATA_W(5)) b4 ();
  rr_sel8_arbiter_if #(.DATA_W(5)) b1 ();

  assign b4.req = req;  assign b4.data_in = data_in;  assign b4.out_ready = out_ready;
  assign b1.req = req;  assign b1.data_in = data_in;  assign b1.out_ready = out_ready;

  rr_sel8_arbiter #(.DATA_W(5), .HOLD_MAX(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  rr_sel8_arbiter #(.DATA_W(5), .HOLD_MAX(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full output snapshot of the HOLD_MAX=4 instance.
  task automatic exp4(input string tag, input logic [7:0] g, input logic [2:0] sel,
                      input logic [4:0] d, input logic v, input logic [7:0] a);
    #1;
    check({tag, ".grant"}, 32'(b4.grant), 32'(g));
    check({tag, ".sel"},   32'({b4.s2, b4.s1, b4.s0}), 32'(sel));
    check({tag, ".data"},  32'(b4.out_data), 32'(d));
    check({tag, ".valid"}, 32'(b4.out_valid), 32'(v));
    check({tag, ".ack"},   32'(b4.ack), 32'(a));
  endtask

  task automatic exp1(input string tag, input logic [7:0] g, input logic [2:0] sel,
                      input logic [4:0] d, input logic v, input logic [7:0] a);
    #1;
    check({tag, ".grant1"}, 32'(b1.grant), 32'(g));
    check({tag, ".sel1"},   32'({b1.s2, b1.s1, b1.s0}), 32'(sel));
    check({tag, ".data1"},  32'(b1.out_data), 32'(d));
    check({tag, ".valid1"}, 32'(b1.out_valid), 32'(v));
    check({tag, ".ack1"},   32'(b1.ack), 32'(a));
  endtask

  initial begin
    int seq1 [9];
    int seq4 [9];
    logic [4:0] w [8];
    seq1 = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
    seq4 = '{0, 0, 0, 0, 2, 2, 2, 2, 0};
    w    = '{5'h10, 5'h11, 5'h12, 5'h13, 5'h14, 5'h15, 5'h16, 5'h17};

    // 1: reset values, then single request from index 0
    tick(); tick();
    exp4("rst", 8'h00, 3'd0, 5'h00, 1'b0, 8'h00);
    rst_n = 1'b1; req = 8'h01; data_in = 40'h11; out_ready = 1'b1;
    tick();
    exp4("t1.busy", 8'h01, 3'd0, 5'h11, 1'b1, 8'h01);
    req = 8'h00;
    tick();
    exp4("t1.idle", 8'h00, 3'd0, 5'h11, 1'b0, 8'h00);

    // 2: all requesting, HOLD_MAX=1 rotates 0..7 then wraps
    rst_n = 1'b0; tick();
    rst_n = 1'b1; req = 8'hFF; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) data_in[i*5 +: 5] = w[i];
    for (int i = 0; i < 9; i++) begin
      tick();
      exp1($sformatf("t2.g%0d", i), 8'(1) << seq1[i], 3'(seq1[i]), w[seq1[i]], 1'b1, 8'(1) << seq1[i]);
      tick();
      check($sformatf("t2.bubble%0d", i), 32'(b1.out_valid), 32'd0);
    end

    // 3: two requesters, HOLD_MAX=4 bursts of four then rotation
    rst_n = 1'b0; tick();
    rst_n = 1'b1; req = 8'h05; out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      exp4($sformatf("t3.g%0d", i), 8'(1) << seq4[i], 3'(seq4[i]), w[seq4[i]], 1'b1, 8'(1) << seq4[i]);
      tick();
      check($sformatf("t3.bubble%0d", i), 32'(b4.out_valid), 32'd0);
    end

    // 4: backpressure on a grant to 3 while req and data3 change
    rst_n = 1'b0; tick();
    rst_n = 1'b1; req = 8'h08; data_in[15 +: 5] = 5'h0C; out_ready = 1'b0;
    tick();
    exp4("t4.grant", 8'h08, 3'd3, 5'h0C, 1'b1, 8'h00);
    req = 8'hFF; data_in[15 +: 5] = 5'h1F;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp4($sformatf("t4.stall%0d", i), 8'h08, 3'd3, 5'h0C, 1'b1, 8'h00);
    end
    out_ready = 1'b1;
    exp4("t4.accept", 8'h08, 3'd3, 5'h0C, 1'b1, 8'h08);
    req = 8'h00;
    tick();
    exp4("t4.idle", 8'h00, 3'd3, 5'h0C, 1'b0, 8'h00);

    // 5: reset while busy drops the word; rescan starts at 0
    rst_n = 1'b0; tick();
    rst_n = 1'b1; req = 8'h10; out_ready = 1'b0;
    tick();
    exp4("t5.grant", 8'h10, 3'd4, 5'h14, 1'b1, 8'h00);
    rst_n = 1'b0; req = 8'h90;
    tick();
    exp4("t5.rst", 8'h00, 3'd0, 5'h00, 1'b0, 8'h00);
    rst_n = 1'b1;
    tick();
    exp4("t5.regrant", 8'h10, 3'd4, 5'h14, 1'b1, 8'h00);
    out_ready = 1'b1;
    exp4("t5.ack", 8'h10, 3'd4, 5'h14, 1'b1, 8'h10);

    // 6: lone requester 7 keeps winning on both instances; new word each round
    req = 8'h80; data_in[35 +: 5] = 5'h1B;
    tick();
    tick();
    exp4("t6.g0", 8'h80, 3'd7, 5'h1B, 1'b1, 8'h80);
    exp1("t6.g0", 8'h80, 3'd7, 5'h1B, 1'b1, 8'h80);
    check("t6.s2", 32'(b4.s2), 32'd1);
    check("t6.s0", 32'(b4.s0), 32'd1);
    for (int i = 1; i < 6; i++) begin
      tick();
      check($sformatf("t6.bubble%0d", i), 32'(b4.out_valid), 32'd0);
      data_in[35 +: 5] = 5'(i);
      tick();
      exp4($sformatf("t6.g%0d", i), 8'h80, 3'd7, 5'(i), 1'b1, 8'h80);
      exp1($sformatf("t6.g%0d", i), 8'h80, 3'd7, 5'(i), 1'b1, 8'h80);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
